// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcode encoding,
// counter width and the long-operation predicate.
package mdu_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage / hazard-unit side bundle of the multiply/divide unit.
interface mdu_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        md_use_d;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, md_op, src_a, src_b, md_use_d,
                   input  busy, done, stall, hi, lo);
   modport slave  (input  start, md_op, src_a, src_b, md_use_d,
                   output busy, done, stall, hi, lo);
endinterface

// File: rtl/mdu_datapath.sv
// Combinational 64-bit product and quotient/remainder; result is {HI, LO}.
module mdu_datapath
   import mdu_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_res,
   output logic        o_div_zero
);

   logic               w_div_zero;
   logic signed [31:0] w_sa;
   logic signed [31:0] w_sb;
   logic signed [31:0] w_sdivisor;
   logic signed [63:0] w_sa64;
   logic signed [63:0] w_sb64;
   logic signed [63:0] w_sprod;
   logic [63:0]        w_uprod;
   logic [31:0]        w_udivisor;
   logic signed [31:0] w_sq;
   logic signed [31:0] w_sr;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;

   assign w_div_zero = (i_b == 32'd0);
   assign w_sa       = i_a;
   assign w_sb       = i_b;
   assign w_sa64     = w_sa;
   assign w_sb64     = w_sb;
   assign w_sprod    = w_sa64 * w_sb64;
   assign w_uprod    = {32'd0, i_a} * {32'd0, i_b};

   // Divisor is forced to 1 on divide-by-zero so the quotient never goes X;
   // the controller discards that result anyway.
   assign w_sdivisor = w_div_zero ? 32'sd1 : w_sb;
   assign w_udivisor = w_div_zero ? 32'd1  : i_b;
   assign w_sq       = w_sa / w_sdivisor;
   assign w_sr       = w_sa % w_sdivisor;
   assign w_uq       = i_a / w_udivisor;
   assign w_ur       = i_a % w_udivisor;

   always_comb begin
      o_res = '0;
      case (i_op)
         MD_MULT:  o_res = w_sprod;
         MD_MULTU: o_res = w_uprod;
         MD_DIV:   o_res = {w_sr, w_sq};
         MD_DIVU:  o_res = {w_ur, w_uq};
         default:  o_res = '0;
      endcase
   end

   assign o_div_zero = w_div_zero;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences multi-cycle ops on a busy
// counter and raises the D-stage stall request.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e             r_state, w_state_n;
   logic [CNT_W-1:0]   r_cnt,   w_cnt_n;
   logic [63:0]        r_res,   w_res_n;
   logic               r_wr,    w_wr_n;
   logic [31:0]        r_hi,    w_hi_n;
   logic [31:0]        r_lo,    w_lo_n;
   logic               r_done,  w_done_n;
   logic [63:0]        w_dp_res;
   logic               w_div_zero;

   mdu_datapath u_dp (
      .i_op       (bus.md_op),
      .i_a        (bus.src_a),
      .i_b        (bus.src_b),
      .o_res      (w_dp_res),
      .o_div_zero (w_div_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_res   <= '0;
         r_wr    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_res   <= w_res_n;
         r_wr    <= w_wr_n;
         r_hi    <= w_hi_n;
         r_lo    <= w_lo_n;
         r_done  <= w_done_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_res_n   = r_res;
      w_wr_n    = r_wr;
      w_hi_n    = r_hi;
      w_lo_n    = r_lo;
      w_done_n  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               case (bus.md_op)
                  MD_MTHI: w_hi_n = bus.src_a;
                  MD_MTLO: w_lo_n = bus.src_a;
                  MD_MULT, MD_MULTU: begin
                     w_res_n   = w_dp_res;
                     w_wr_n    = 1'b1;
                     w_cnt_n   = CNT_W'(MULT_CYCLES);
                     w_state_n = ST_BUSY;
                  end
                  MD_DIV, MD_DIVU: begin
                     w_res_n   = w_dp_res;
                     w_wr_n    = ~w_div_zero;
                     w_cnt_n   = CNT_W'(DIV_CYCLES);
                     w_state_n = ST_BUSY;
                  end
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            // Starts are ignored here; the result commits on the last busy cycle.
            if (r_cnt == CNT_W'(1)) begin
               if (r_wr) begin
                  w_hi_n = r_res[63:32];
                  w_lo_n = r_res[31:0];
               end
               w_cnt_n   = '0;
               w_done_n  = 1'b1;
               w_state_n = ST_IDLE;
            end else begin
               w_cnt_n = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   assign bus.busy  = (r_state == ST_BUSY);
   assign bus.done  = r_done;
   assign bus.hi    = r_hi;
   assign bus.lo    = r_lo;
   assign bus.stall = bus.md_use_d & (bus.busy | (bus.start & is_long_op(bus.md_op)));

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide controller for the E stage of the five-stage MIPS pipeline; owns the HI/LO architectural registers.
- Accepts mult/multu/div/divu/mthi/mtlo from E and runs multi-cycle operations on a busy counter.
- Raises a stall request to the hazard unit while a D-stage instruction needs HI/LO or the MDU.
- HI/LO values feed the E-stage mfhi/mflo result path, which the E/M pipeline register carries forward.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (legal 1..15).
- DIV_CYCLES, 10, busy duration of div/divu in cycles (legal 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  E-stage instruction is an MDU op; qualifies md_op
- md_op  in  3  operation code (see Decomposition)
- src_a  in  32  rs operand (forwarded value)
- src_b  in  32  rt operand (forwarded value)
- md_use_d  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse on the edge HI/LO commit a mult/div result
- stall  out  1  stall request to the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Reset: hi=0, lo=0, busy=0, done=0, counter=0, latched result=0. Reset mid-operation aborts the op; HI/LO go to 0, not to the result.
- start sampled only when busy=0. start while busy=1 is ignored; hazard stalling makes this unreachable, but the RTL must ignore it.
- MTHI/MTLO with start: hi (or lo) <= src_a on the same edge; busy stays 0; done stays 0.
- MULT/MULTU/DIV/DIVU with start: on that edge the block latches the full result:
  - MULT: signed 64-bit product.
  - MULTU: unsigned 64-bit product.
  - DIV/DIVU: quotient to LO, remainder to HI; signed uses truncation toward zero with remainder sign = dividend sign.
  - The counter loads N (MULT_CYCLES or DIV_CYCLES); busy=1 from the next cycle.
- Counter decrements each cycle while busy. On the edge where counter==1:
  - hi/lo <= latched result; counter <= 0; busy <= 0; done <= 1 for one cycle.
  - busy is therefore high exactly N cycles, and new hi/lo are visible in the first cycle busy=0.
- Divide by zero (src_b==0 on DIV/DIVU): full busy period runs; HI/LO are not written; done still pulses. Never produces X.
- start with md_op NONE or an undefined code: no effect.
- stall = md_use_d & (busy | (start & md_op is MULT/MULTU/DIV/DIVU)). This is combinational; the hazard unit freezes PC/D and bubbles E.
- Non-MDU E instructions proceed while busy.
- hi/lo outputs hold between writes.

Decomposition:
- Package mdu_pkg:
  - md_op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Counter width constant CNT_W=4.
  - Helper predicate is_long_op(op).
- One natural sub-module, mdu_datapath: combinational 64-bit product and quotient/remainder plus the divide-by-zero flag.
- mdu_ctrl keeps the counter, result latch, HI/LO and stall logic.

Test Plan:
- Reset then MTHI src_a=0x1234 -> hi=0x1234 next cycle, busy=0, stall=0; MTLO 0xABCD -> lo=0xABCD.
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- DIV by zero with hi=0x11, lo=0x22 preloaded -> busy 10 cycles, done pulses, hi/lo unchanged at 0x11/0x22.
- md_use_d=1 held from the start cycle of MULT -> stall=1 in the start cycle and all 5 busy cycles, stall=0 the cycle busy falls. With md_use_d=0, stall=0 throughout.
- Reset asserted on the 3rd busy cycle of DIVU 100/7 -> next cycle busy=0, hi=lo=0, no done pulse. A second start during busy -> ignored, original result committed.
